decoder_gate_arbiter: RTL

- Shares one `decoder_2x4` instance among N_REQ requesters. The decoder has ports in[1:0] and out[3:0], with out[k]=1 iff in==k.
- Each requester submits a two-input logic operation (AND/OR/NAND/NOR/XOR/XNOR/A/B) on its own operand bits.
- The block arbitrates round-robin, drives the shared decoder with the winner's operands and forms the result as the OR of decoder outputs selected by an opcode minterm mask.
- It returns a registered result tagged with the requester ID through a valid/ready handshake, and sits between the gate-level decoder datapath and its multiple users.

---
 rtl/decoder_gate_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/decoder_gate_arbiter.sv
// Round-robin arbiter that shares a single gate-level 2-to-4 decoder among
// N_REQ requesters. Each granted operation is evaluated as the OR of the
// decoder outputs selected by the opcode's minterm mask. The result comes
// back registered, tagged with the requester index, over a valid/ready
// handshake.

// Gate-level 2-to-4 decoder: out[k] = 1 iff in == k.
module decoder_2x4 (
   input  logic [1:0] in,
   output logic [3:0] out
);

   assign out[0] = ~in[1] & ~in[0];
   assign out[1] = ~in[1] &  in[0];
   assign out[2] =  in[1] & ~in[0];
   assign out[3] =  in[1] &  in[0];

endmodule

module decoder_gate_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [3*N_REQ-1:0] op,
   input  logic [N_REQ-1:0]   a,
   input  logic [N_REQ-1:0]   b,
   output logic [N_REQ-1:0]   gnt,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res,
   output logic [ID_W-1:0]    res_id,
   output logic [7:0]         txn_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic              a_q, a_d;
   logic              b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              res_q, res_d;
   logic              valid_q, valid_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic [7:0]        cnt_q, cnt_d;

   logic [ID_W-1:0]   win_id;
   logic              win_found;
   logic [3:0]        dec_out;
   logic [3:0]        mask;
   logic              gate_res;

   // The one and only evaluation path: the shared decoder fed by the
   // captured operands, a is the high select bit.
   decoder_2x4 u_dec (
      .in  ({a_q, b_q}),
      .out (dec_out)
   );

   // Round-robin search starting at ptr; walking offsets from the far end
   // down lets the closest pending requester overwrite earlier candidates.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      win_id    = '0;
      win_found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         logic [ID_W-1:0] idx;
         idx = ptr_q + ID_W'(k);
         if (req[idx]) begin
            win_id    = idx;
            win_found = 1'b1;
         end
      end
   end

   // Opcode to minterm mask; bit k selects decoder output k = {a,b}.
   always_comb begin
      mask = 4'b0000;
      case (op_q)
         3'd0:    mask = 4'b1000; // AND
         3'd1:    mask = 4'b1110; // OR
         3'd2:    mask = 4'b0111; // NAND
         3'd3:    mask = 4'b0001; // NOR
         3'd4:    mask = 4'b0110; // XOR
         3'd5:    mask = 4'b1001; // XNOR
         3'd6:    mask = 4'b1100; // A
         default: mask = 4'b1010; // B
      endcase
      gate_res = |(mask & dec_out);
   end

   // Next-state and output logic for the IDLE -> EVAL -> RESP cycle.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      id_d     = id_q;
      res_d    = res_q;
      valid_d  = valid_q;
      res_id_d = res_id_q;
      cnt_d    = cnt_q;

      case (state_q)
         ST_IDLE: begin
            gnt_d = '0;
            if (win_found) begin
               gnt_d[win_id] = 1'b1;
               a_d           = a[win_id];
               b_d           = b[win_id];
               op_d          = op[3*int'(win_id) +: 3];
               id_d          = win_id;
               ptr_d         = win_id + ID_W'(1);
               state_d       = ST_EVAL;
            end
         end
         ST_EVAL: begin
            gnt_d    = '0;
            res_d    = gate_res;
            res_id_d = id_q;
            valid_d  = 1'b1;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (valid_q && res_ready) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset; a reset drops any transaction
   // in flight without counting it.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         op_q     <= 3'd0;
         id_q     <= '0;
         res_q    <= 1'b0;
         valid_q  <= 1'b0;
         res_id_q <= '0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         id_q     <= id_d;
         res_q    <= res_d;
         valid_q  <= valid_d;
         res_id_q <= res_id_d;
         cnt_q    <= cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign res_valid = valid_q;
   assign res       = res_q;
   assign res_id    = res_id_q;
   assign txn_cnt   = cnt_q;

endmodule
